order_function_register: RTL and testbench

Serial-to-parallel order register for the EDSAC control section. It owns the minor-cycle digit counter. On request it captures one 17-digit order arriving LSB-first from the order tank. It then presents the function digits f13–f17 as complementary pos/neg pairs, plus the address and long/short flag, for the order decoders downstream. It also generates the digit-0 timing pulse `o_dy_0` that the decoders qualify on.

---
 rtl/edsac_pkg.sv | 30 +++
 rtl/order_function_register_if.sv | 43 ++++
 rtl/order_function_register_digit_timer.sv | 45 ++++
 rtl/order_function_register.sv | 116 +++++++++++
 tb/tb_order_function_register.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/edsac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edsac_pkg
// Description : Shared EDSAC control-section constants. It defines the
//               minor-cycle length, the digit positions of each order field
//               and the order-register FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package edsac_pkg;

    // Digit times per minor cycle: the dy_0 gap digit plus 17 order digits.
    localparam int DIGITS_PER_MINOR = 18;
    localparam int DY_W             = 5;

    // Digit positions of the order fields. Digit 1 arrives first.
    localparam int L_DIGIT = 1;
    localparam int ADDR_LO = 2;
    localparam int ADDR_HI = 11;
    localparam int SPARE   = 12;
    localparam int FN_LO   = 13;
    localparam int FN_HI   = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_SHIFT = 2'd2
    } ofr_state_t;

endpackage : edsac_pkg
`default_nettype wire

// File: rtl/order_function_register_if.sv
`default_nettype none
// ============================================================================
// Module      : order_function_register_if
// Description : Bundle between the order tank/control sequencer (master) and
//               the order function register (slave).
//   master -> slave : digit_en, order_in, fetch, abort
//   slave -> master : o_dy_0, dy_count, f13..f17 pos/neg, addr, long_order,
//                     order_valid, busy
// Revision    : 1.0 - initial release
// ============================================================================
interface order_function_register_if #(
    parameter int ADDR_W = 10
);
    logic              digit_en;
    logic              order_in;
    logic              fetch;
    logic              abort;
    logic              o_dy_0;
    logic [4:0]        dy_count;
    logic              f13_pos, f14_pos, f15_pos, f16_pos, f17_pos;
    logic              f13_neg, f14_neg, f15_neg, f16_neg, f17_neg;
    logic [ADDR_W-1:0] addr;
    logic              long_order;
    logic              order_valid;
    logic              busy;

    modport master (
        output digit_en, order_in, fetch, abort,
        input  o_dy_0, dy_count,
               f13_pos, f14_pos, f15_pos, f16_pos, f17_pos,
               f13_neg, f14_neg, f15_neg, f16_neg, f17_neg,
               addr, long_order, order_valid, busy
    );

    modport slave (
        input  digit_en, order_in, fetch, abort,
        output o_dy_0, dy_count,
               f13_pos, f14_pos, f15_pos, f16_pos, f17_pos,
               f13_neg, f14_neg, f15_neg, f16_neg, f17_neg,
               addr, long_order, order_valid, busy
    );
endinterface : order_function_register_if
`default_nettype wire

// File: rtl/order_function_register_digit_timer.sv
`default_nettype none
// ============================================================================
// Module      : digit_timer
// Description : Free-running mod-DIGITS minor-cycle digit counter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_digit_en  : advance one digit time
//   o_dy_count  : current digit number (registered)
//   o_dy_0      : high while the count is 0 (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module digit_timer #(
    parameter int DIGITS = 18,
    parameter int CNT_W  = 5
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_digit_en,
    output logic      [CNT_W-1:0] o_dy_count,
    output logic                  o_dy_0
);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIGITS - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_dy_0;

    // dy_0 is decoded from the next count so it is registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_dy_0  <= 1'b1;
        end else if (i_digit_en) begin
            if (r_count == C_LAST) begin
                r_count <= '0;
                r_dy_0  <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
                r_dy_0  <= 1'b0;
            end
        end
    end

    assign o_dy_count = r_count;
    assign o_dy_0     = r_dy_0;
endmodule : digit_timer
`default_nettype wire

// File: rtl/order_function_register.sv
`default_nettype none
// ============================================================================
// Module      : order_function_register
// Description : Serial-to-parallel order register for the EDSAC control
//               section. Captures a 17-digit order (LSB first) on request and
//               presents function digits as pos/neg pairs, plus address and
//               long/short flag, from a holding register.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of order_function_register_if
// Revision    : 1.0 - initial release
// ============================================================================
module order_function_register
    import edsac_pkg::*;
#(
    parameter int DIGITS = DIGITS_PER_MINOR,
    parameter int ADDR_W = 10
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    order_function_register_if.slave  bus
);
    localparam logic [DY_W-1:0] C_DY_LAST = DY_W'(FN_HI);

    logic [DY_W-1:0]   w_dy_count;
    logic              w_dy_0;
    logic [16:0]       w_word;
    logic              w_unused_bits;

    ofr_state_t        r_state;
    logic [16:0]       r_shift;
    logic              r_long;
    logic [ADDR_W-1:0] r_addr;
    logic [4:0]        r_fn;
    logic              r_valid;

    digit_timer #(
        .DIGITS (DIGITS),
        .CNT_W  (DY_W)
    ) u_digit_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_digit_en (bus.digit_en),
        .o_dy_count (w_dy_count),
        .o_dy_0     (w_dy_0)
    );

    // Shift right so that digit 1 ends in bit 0 once all 17 digits are in.
    // The capture reads this next value so the dy_17 digit is included.
    assign w_word = {bus.order_in, r_shift[16:1]};

    // Spare digit and the bit shifted out are intentionally discarded.
    assign w_unused_bits = ^{w_word[SPARE-1], r_shift[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_long  <= 1'b0;
            r_addr  <= '0;
            r_fn    <= '0;
            r_valid <= 1'b0;
        end else if (bus.abort) begin
            // Abort outranks fetch and digit_en; holding register untouched.
            if (r_state != ST_IDLE) begin
                r_state <= ST_IDLE;
                r_shift <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.fetch) begin
                        r_state <= ST_ARM;
                        r_valid <= 1'b0;
                    end
                end
                ST_ARM: begin
                    // Wait for a whole minor cycle to start at dy_0.
                    if (bus.digit_en && (w_dy_count == '0)) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bus.digit_en && (w_dy_count != '0)) begin
                        r_shift <= w_word;
                        if (w_dy_count == C_DY_LAST) begin
                            r_long  <= w_word[L_DIGIT-1];
                            r_addr  <= w_word[ADDR_LO-1 +: ADDR_W];
                            r_fn    <= w_word[FN_HI-1:FN_LO-1];
                            r_valid <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.dy_count    = w_dy_count;
    assign bus.o_dy_0      = w_dy_0;
    assign bus.f13_pos     = r_fn[0];
    assign bus.f14_pos     = r_fn[1];
    assign bus.f15_pos     = r_fn[2];
    assign bus.f16_pos     = r_fn[3];
    assign bus.f17_pos     = r_fn[4];
    assign bus.f13_neg     = ~r_fn[0];
    assign bus.f14_neg     = ~r_fn[1];
    assign bus.f15_neg     = ~r_fn[2];
    assign bus.f16_neg     = ~r_fn[3];
    assign bus.f17_neg     = ~r_fn[4];
    assign bus.addr        = r_addr;
    assign bus.long_order  = r_long;
    assign bus.order_valid = r_valid;
    assign bus.busy        = (r_state != ST_IDLE);
endmodule : order_function_register
`default_nettype wire

// File: tb/tb_order_function_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_order_function_register
// Description : Self-checking bench for order_function_register with a
//               queue-based reference model of the order transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_order_function_register;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    order_function_register_if #(.ADDR_W(10)) bus ();

    order_function_register #(.DIGITS(18), .ADDR_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: digit number, capture phase (0 idle, 1 waiting for
    // dy_0, 2 collecting digits), collected digits and decoded fields.
    int         m_cnt;
    int         m_phase;
    logic       m_bits[$];
    logic       m_valid;
    logic       m_L;
    logic [9:0] m_addr;
    logic [4:0] m_f;

    // Order currently circulating in the tank.
    logic       t_L;
    logic [9:0] t_addr;
    logic [4:0] t_f;

    function automatic void model_reset();
        m_cnt = 0; m_phase = 0; m_bits.delete();
        m_valid = 1'b0; m_L = 1'b0; m_addr = '0; m_f = '0;
    endfunction

    function automatic void model_step(logic en, logic din, logic f, logic ab);
        if (ab) begin
            if (m_phase != 0) begin m_phase = 0; m_bits.delete(); end
        end else if (m_phase == 0) begin
            if (f) begin m_phase = 1; m_valid = 1'b0; end
        end else if (en) begin
            if (m_phase == 1 && m_cnt == 0) begin
                m_phase = 2; m_bits.delete();
            end else if (m_phase == 2 && m_cnt >= 1) begin
                m_bits.push_back(din);
                if (m_cnt == 17) begin
                    m_L = m_bits[0];
                    for (int i = 0; i < 10; i++) m_addr[i] = m_bits[1 + i];
                    for (int i = 0; i < 5; i++)  m_f[i]    = m_bits[12 + i];
                    m_valid = 1'b1;
                    m_phase = 0;
                end
            end
        end
        if (en) m_cnt = (m_cnt + 1) % 18;
    endfunction

    function automatic logic tank_bit(int d);
        if (d == 1)              return t_L;
        if (d >= 2 && d <= 11)   return t_addr[d - 2];
        if (d >= 13 && d <= 17)  return t_f[d - 13];
        return 1'($urandom);
    endfunction

    function automatic logic [28:0] exp_vec();
        return {(m_cnt == 0), 5'(m_cnt), m_f, ~m_f, m_addr, m_L, m_valid, (m_phase != 0)};
    endfunction

    function automatic logic [28:0] obs_vec();
        return {bus.o_dy_0, bus.dy_count,
                bus.f17_pos, bus.f16_pos, bus.f15_pos, bus.f14_pos, bus.f13_pos,
                bus.f17_neg, bus.f16_neg, bus.f15_neg, bus.f14_neg, bus.f13_neg,
                bus.addr, bus.long_order, bus.order_valid, bus.busy};
    endfunction

    // One clk: drive at negedge, model the edge, leave outputs settled 1ns after.
    task automatic cyc(input logic en, input logic din, input logic f, input logic ab);
        @(negedge clk);
        bus.digit_en = en; bus.order_in = din; bus.fetch = f; bus.abort = ab;
        model_step(en, din, f, ab);
        @(posedge clk);
        #1;
        bus.digit_en = 1'b0; bus.fetch = 1'b0; bus.abort = 1'b0;
    endtask

    // One digit time, with a few random idle clocks in front of the strobe.
    task automatic strobe(input logic f, input logic ab);
        int gaps;
        gaps = $urandom_range(0, 2);
        repeat (gaps) cyc(1'b0, 1'($urandom), 1'b0, 1'b0);
        cyc(1'b1, tank_bit(m_cnt), f, ab);
    endtask

    task automatic advance_to(input int d);
        for (int k = 0; k < 20 && m_cnt != d; k++) strobe(1'b0, 1'b0);
    endtask

    task automatic new_tank();
        t_L = 1'($urandom); t_addr = 10'($urandom); t_f = 5'($urandom);
    endtask

    task automatic test_reset();
        bus.digit_en = 1'b0; bus.order_in = 1'b0; bus.fetch = 1'b0; bus.abort = 1'b0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.o_dy_0 !== 1'b1) begin n_fail++; $display("FAIL reset_dy0: got %b expected 1", bus.o_dy_0); end
        n_tests++;
        if (bus.dy_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.dy_count); end
        n_tests++;
        if ({bus.f17_neg, bus.f16_neg, bus.f15_neg, bus.f14_neg, bus.f13_neg} !== 5'b11111) begin
            n_fail++; $display("FAIL reset_fneg: not all ones");
        end
        n_tests++;
        if ({bus.f17_pos, bus.f16_pos, bus.f15_pos, bus.f14_pos, bus.f13_pos} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_fpos: not all zeros");
        end
        n_tests++;
        if ({bus.order_valid, bus.busy, bus.long_order, bus.addr} !== 13'd0) begin
            n_fail++; $display("FAIL reset_flags: got %h expected 0", {bus.order_valid, bus.busy, bus.long_order, bus.addr});
        end
    endtask

    task automatic test_capture();
        int  k;
        t_L = 1'b0; t_addr = 10'd5; t_f = 5'b11100;
        advance_to(5);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (k = 0; k < 80 && !m_valid; k++) begin
            strobe(1'b0, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL capture_cycle: got %h expected %h", obs_vec(), exp_vec());
            end
        end
        n_tests++;
        if (bus.order_valid !== 1'b1) begin n_fail++; $display("FAIL capture_valid: got %b expected 1", bus.order_valid); end
        n_tests++;
        if ({bus.f17_pos, bus.f16_pos, bus.f15_pos, bus.f14_neg, bus.f13_neg} !== 5'b11111) begin
            n_fail++; $display("FAIL capture_fn: pos/neg pattern wrong");
        end
        n_tests++;
        if (bus.addr !== 10'd5 || bus.long_order !== 1'b0) begin
            n_fail++; $display("FAIL capture_addr: got %0d/%b expected 5/0", bus.addr, bus.long_order);
        end
    endtask

    task automatic test_random_orders();
        for (int n = 0; n < 4; n++) begin
            new_tank();
            advance_to($urandom_range(0, 17));
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            for (int k = 0; k < 80 && m_phase != 0; k++) begin
                strobe(1'b0, 1'b0);
                n_tests++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++; $display("FAIL random_cycle: got %h expected %h", obs_vec(), exp_vec());
                end
            end
            n_tests++;
            if (bus.addr !== t_addr || bus.long_order !== t_L || bus.f13_pos !== t_f[0] || bus.f17_pos !== t_f[4]) begin
                n_fail++; $display("FAIL random_fields: got %0d/%b expected %0d/%b", bus.addr, bus.long_order, t_addr, t_L);
            end
        end
    endtask

    task automatic test_fetch_dy0();
        int n;
        new_tank();
        advance_to(0);
        cyc(1'b1, tank_bit(0), 1'b1, 1'b0);
        n = 1;
        while (!bus.order_valid && n < 60) begin
            strobe(1'b0, 1'b0);
            n++;
        end
        n_tests++;
        if (n !== 36) begin n_fail++; $display("FAIL fetch_dy0_latency: got %0d strobes expected 36", n); end
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL fetch_dy0_result: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_hold();
        t_L = 1'b1; t_addr = 10'd1023; t_f = 5'($urandom);
        advance_to($urandom_range(0, 17));
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 80 && m_phase != 0; k++) strobe(1'b0, 1'b0);
        n_tests++;
        if (bus.addr !== 10'd1023 || bus.long_order !== 1'b1 || bus.order_valid !== 1'b1) begin
            n_fail++; $display("FAIL hold_first: got %0d/%b expected 1023/1", bus.addr, bus.long_order);
        end
        t_L = 1'b0; t_addr = 10'($urandom_range(0, 1022)); t_f = 5'($urandom);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 80 && m_phase != 0; k++) begin
            strobe(1'b0, 1'b0);
            if (m_phase != 0) begin
                n_tests++;
                if (bus.addr !== 10'd1023 || bus.long_order !== 1'b1 || bus.order_valid !== 1'b0) begin
                    n_fail++; $display("FAIL hold_during: got %0d/%b/%b expected 1023/1/0", bus.addr, bus.long_order, bus.order_valid);
                end
            end
        end
        n_tests++;
        if (bus.addr !== t_addr || bus.long_order !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL hold_second: got %0d expected %0d", bus.addr, t_addr);
        end
    endtask

    task automatic test_abort();
        new_tank();
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 80 && !(m_phase == 2 && m_cnt == 9); k++) strobe(1'b0, 1'b0);
        cyc(1'b1, tank_bit(9), 1'b1, 1'b1);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.order_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_flags: got busy=%b valid=%b expected 0/0", bus.busy, bus.order_valid);
        end
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL abort_outputs: got %h expected %h", obs_vec(), exp_vec());
        end
        new_tank();
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 80 && m_phase != 0; k++) strobe(1'b0, 1'b0);
        n_tests++;
        if (bus.addr !== t_addr || bus.long_order !== t_L || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL abort_recapture: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid_shift();
        new_tank();
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 80 && !(m_phase == 2 && m_cnt == 6); k++) strobe(1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL async_reset: got %h expected %h", obs_vec(), exp_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        new_tank();
        advance_to($urandom_range(1, 17));
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 80 && m_phase != 0; k++) strobe(1'b0, 1'b0);
        n_tests++;
        if (bus.addr !== t_addr || bus.order_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_recapture: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_random_orders();
        test_fetch_dy0();
        test_hold();
        test_abort();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_order_function_register
`default_nettype wire
